// File: rtl/vga_sync_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_monitor
//  Brief    : Cycle-exact checker of VGA hsync/vsync timing, blanking and
//             active-pixel content; reports lock state and sticky errors.
//  Revision : 1.0
// ============================================================================
module vga_sync_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC_W = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC_W = 2,
    parameter int V_BP     = 33
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [5:0]  rgb,
    input  logic        clear_err,
    output logic [4:0]  err,
    output logic        locked,
    output logic        frame_pulse,
    output logic [15:0] frame_count,
    output logic [18:0] pix_count
);

    localparam logic [11:0] c_h_total  = 12'(H_ACTIVE + H_FP + H_SYNC_W + H_BP);
    localparam logic [10:0] c_v_total  = 11'(V_ACTIVE + V_FP + V_SYNC_W + V_BP);
    localparam logic [10:0] c_h_sync_w = 11'(H_SYNC_W);
    localparam logic [9:0]  c_v_sync_w = 10'(V_SYNC_W);
    localparam logic [10:0] c_x_lo     = 11'(H_SYNC_W + H_BP);
    localparam logic [10:0] c_x_hi     = 11'(H_SYNC_W + H_BP + H_ACTIVE);
    localparam logic [9:0]  c_y_lo     = 10'(V_SYNC_W + V_BP);
    localparam logic [9:0]  c_y_hi     = 10'(V_SYNC_W + V_BP + V_ACTIVE);

    localparam logic [1:0] c_st_search = 2'd0;
    localparam logic [1:0] c_st_hsync  = 2'd1;
    localparam logic [1:0] c_st_vsync  = 2'd2;
    localparam logic [1:0] c_st_locked = 2'd3;

    logic        r_hs_q, r_vs_q, r_hs_p, r_vs_p;
    logic [5:0]  r_rgb_q;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_v_pend;
    logic [1:0]  r_state;
    logic        r_frame_err;
    logic [18:0] r_acc;

    logic        w_ha, w_hd, w_va, w_vd, w_fs;
    logic [10:0] w_x;
    logic [9:0]  w_y;
    logic        w_v_pend_nxt;
    logic        w_hchk, w_vchk, w_active, w_pix_hit, w_any_err;
    logic [4:0]  w_new_err;
    logic [1:0]  w_state_nxt;

    assign w_ha = r_hs_p & ~r_hs_q;
    assign w_hd = ~r_hs_p & r_hs_q;
    assign w_va = r_vs_p & ~r_vs_q;
    assign w_vd = ~r_vs_p & r_vs_q;

    // A vsync assert in the same cycle as hsync assert already counts as pending.
    assign w_fs         = w_ha & (r_v_pend | w_va);
    assign w_v_pend_nxt = w_fs ? 1'b0 : (w_va | r_v_pend);

    // w_x / w_y are the coordinates of the pixel currently held in r_rgb_q.
    assign w_x = w_ha ? 11'd0 : ((r_x == 11'h7FF) ? r_x : r_x + 11'd1);
    assign w_y = w_fs ? 10'd0 :
                 w_ha ? ((r_y == 10'h3FF) ? r_y : r_y + 10'd1) : r_y;

    assign w_hchk = (r_state != c_st_search);
    assign w_vchk = (r_state == c_st_vsync) || (r_state == c_st_locked);

    assign w_active  = (w_x >= c_x_lo) && (w_x < c_x_hi) &&
                       (w_y >= c_y_lo) && (w_y < c_y_hi);
    assign w_pix_hit = w_active && (r_rgb_q != 6'd0);

    assign w_new_err[0] = w_ha & w_hchk & (({1'b0, r_x} + 12'd1) != c_h_total);
    assign w_new_err[1] = w_hd & w_hchk & (w_x != c_h_sync_w);
    assign w_new_err[2] = w_fs & w_vchk & (({1'b0, r_y} + 11'd1) != c_v_total);
    assign w_new_err[3] = w_vd & w_vchk & (w_y != c_v_sync_w);
    assign w_new_err[4] = w_vchk & ~w_active & (r_rgb_q != 6'd0);
    assign w_any_err    = |w_new_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_search: if (w_ha) w_state_nxt = c_st_hsync;
            c_st_hsync:  if (w_fs) w_state_nxt = c_st_vsync;
            c_st_vsync:  if (w_fs && !r_frame_err && !w_any_err) w_state_nxt = c_st_locked;
            c_st_locked: if (w_any_err || clear_err) w_state_nxt = c_st_vsync;
            default:     w_state_nxt = c_st_search;
        endcase
    end

    assign locked = (r_state == c_st_locked);

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            r_hs_q      <= 1'b1;
            r_vs_q      <= 1'b1;
            r_hs_p      <= 1'b1;
            r_vs_p      <= 1'b1;
            r_rgb_q     <= 6'd0;
            r_x         <= 11'd0;
            r_y         <= 10'd0;
            r_v_pend    <= 1'b0;
            r_state     <= c_st_search;
            r_frame_err <= 1'b0;
            r_acc       <= 19'd0;
            err         <= 5'd0;
            frame_pulse <= 1'b0;
            frame_count <= 16'd0;
            pix_count   <= 19'd0;
        end else begin
            r_hs_q   <= h_sync;
            r_vs_q   <= v_sync;
            r_hs_p   <= r_hs_q;
            r_vs_p   <= r_vs_q;
            r_rgb_q  <= rgb;
            r_x      <= w_x;
            r_y      <= w_y;
            r_v_pend <= w_v_pend_nxt;
            r_state  <= w_state_nxt;
            // An error on the frame-start cycle belongs to the frame that is ending.
            r_frame_err <= w_fs ? 1'b0 : (r_frame_err | w_any_err);
            err         <= clear_err ? w_new_err : (err | w_new_err);
            frame_pulse <= w_fs & w_vchk;
            if (w_fs & w_vchk) begin
                frame_count <= frame_count + 16'd1;
            end
            if (w_fs) begin
                pix_count <= r_acc;
                r_acc     <= {18'd0, w_pix_hit};
            end else begin
                r_acc     <= r_acc + {18'd0, w_pix_hit};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_monitor
//  Brief    : Scoreboard bench for vga_sync_monitor on a scaled-down
//             31x15 raster (16x8 active).
//  Revision : 1.0
// ============================================================================
module tb_vga_sync_monitor;

    localparam int HACT = 16, HFP = 4, HSW = 6, HBP = 5;
    localparam int VACT = 8,  VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = 31, VT = 15;
    localparam int XLO = 11, XHI = 27, YLO = 5, YHI = 13;
    localparam int PIX_FULL = 128;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic        h_sync, v_sync, clear_err;
    logic [5:0]  rgb;
    logic [4:0]  err;
    logic        locked, frame_pulse;
    logic [15:0] frame_count;
    logic [18:0] pix_count;

    typedef struct packed {
        logic [4:0]  e_err;
        logic        e_locked;
        logic [15:0] e_fc;
        logic [18:0] e_pix;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   pattern = 1'b0;

    vga_sync_monitor #(
        .H_ACTIVE(HACT), .H_FP(HFP), .H_SYNC_W(HSW), .H_BP(HBP),
        .V_ACTIVE(VACT), .V_FP(VFP), .V_SYNC_W(VSW), .V_BP(VBP)
    ) dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .rgb         (rgb),
        .clear_err   (clear_err),
        .err         (err),
        .locked      (locked),
        .frame_pulse (frame_pulse),
        .frame_count (frame_count),
        .pix_count   (pix_count)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void expect_pulse(input logic [4:0] e, input logic l, input int fc, input int pix);
        exp_t t;
        t.e_err    = e;
        t.e_locked = l;
        t.e_fc     = 16'(fc);
        t.e_pix    = 19'(pix);
        exp_q.push_back(t);
    endfunction

    // One raster line; gx places a glitch pixel, cx pulses clear_err (-1 = none).
    task automatic drive_line(input int l, input int htot, input int hsw, input bit vlow,
                              input int gx, input int cx);
        for (int h = 0; h < htot; h++) begin
            h_sync = (h < hsw) ? 1'b0 : 1'b1;
            v_sync = ~vlow;
            rgb    = 6'b000000;
            if (h >= XLO && h < XHI && l >= YLO && l < YHI && !(pattern && ((h - XLO) % 2 == 0)))
                rgb = 6'b110000;
            if (h == gx) rgb = 6'b000011;
            clear_err = (h == cx);
            @(negedge pixel_clk);
        end
    endtask

    task automatic drive_norm(input int l);
        drive_line(l, HT, HSW, (l < VSW), -1, -1);
    endtask

    task automatic drive_frame();
        for (int l = 0; l < VT; l++) drive_norm(l);
    endtask

    // Scoreboard monitor: every frame_pulse consumes one expectation.
    initial begin
        forever begin
            @(posedge pixel_clk);
            #1;
            if (frame_pulse === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame_pulse: got pulse, required none (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_err",         64'(err),         64'(mon_e.e_err));
                    chk("pulse_locked",      64'(locked),      64'(mon_e.e_locked));
                    chk("pulse_frame_count", 64'(frame_count), 64'(mon_e.e_fc));
                    chk("pulse_pix_count",   64'(pix_count),   64'(mon_e.e_pix));
                end
                @(posedge pixel_clk);
                #1;
                chk("pulse_width", 64'(frame_pulse), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; h_sync = 1'b1; v_sync = 1'b1; rgb = 6'd0; clear_err = 1'b0;
        #3;
        chk("reset_outputs", 64'({err, locked, frame_pulse, frame_count, pix_count}), 64'd0);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        reset = 1'b1;

        // Lead-in tail of a frame: first HA enters HSYNC, frame 1 start enters VSYNC.
        for (int l = 12; l < VT; l++) drive_norm(l);
        drive_frame();
        expect_pulse(5'b00000, 1'b1, 1, PIX_FULL);
        drive_frame();

        // Line 4 is one clock short: HPER two cycles after the HA of line 5.
        expect_pulse(5'b00000, 1'b1, 2, PIX_FULL);
        for (int l = 0; l < 4; l++) drive_norm(l);
        drive_line(4, HT - 1, HSW, 1'b0, -1, -1);
        fork
            drive_norm(5);
            begin
                @(posedge pixel_clk); #1;
                chk("hper_not_early", 64'(err), 64'd0);
                @(posedge pixel_clk); #1;
                chk("hper_latency", 64'(err), 64'b00001);
                chk("hper_unlock", 64'(locked), 64'd0);
            end
        join
        for (int l = 6; l < VT; l++) drive_norm(l);

        // Narrow hsync pulse, then clear_err.
        expect_pulse(5'b00001, 1'b0, 3, PIX_FULL);
        for (int l = 0; l < 6; l++) drive_norm(l);
        drive_line(6, HT, HSW - 1, 1'b0, -1, -1);
        chk("hwid_set", 64'(err), 64'b00011);
        drive_norm(7);
        drive_norm(8);
        drive_line(9, HT, HSW, 1'b0, -1, 2);
        chk("clear_err", 64'(err), 64'd0);
        for (int l = 10; l < VT; l++) drive_norm(l);
        expect_pulse(5'b00000, 1'b0, 4, PIX_FULL);
        drive_frame();

        // Vsync three lines wide in a 16-line frame.
        expect_pulse(5'b00000, 1'b1, 5, PIX_FULL);
        for (int l = 0; l < VT + 1; l++) drive_line(l, HT, HSW, (l < VSW + 1), -1, -1);

        // Clean frame with every other active pixel black, cleared early.
        expect_pulse(5'b01100, 1'b0, 6, PIX_FULL);
        pattern = 1'b1;
        drive_norm(0);
        drive_line(1, HT, HSW, 1'b1, -1, 2);
        for (int l = 2; l < VT; l++) drive_norm(l);
        pattern = 1'b0;

        // Non-black pixel at x=0 of an active line.
        expect_pulse(5'b00000, 1'b1, 7, 64);
        for (int l = 0; l < 7; l++) drive_norm(l);
        drive_line(7, HT, HSW, 1'b0, 0, -1);
        chk("blank_set", 64'(err), 64'b10000);
        for (int l = 8; l < VT; l++) drive_norm(l);

        // Asynchronous reset in the middle of line 7.
        expect_pulse(5'b10000, 1'b0, 8, PIX_FULL);
        for (int l = 0; l < 7; l++) drive_norm(l);
        fork
            drive_norm(7);
            begin
                repeat (10) @(posedge pixel_clk);
                #2;
                reset = 1'b0;
                #1;
                chk("async_reset_outputs", 64'({err, locked, frame_pulse, frame_count, pix_count}), 64'd0);
                repeat (3) @(negedge pixel_clk);
                #2;
                reset = 1'b1;
            end
        join
        for (int l = 8; l < VT; l++) drive_norm(l);
        drive_frame();
        chk("relock_wait", 64'(locked), 64'd0);

        // Relock, then a missing hsync long enough to saturate x.
        expect_pulse(5'b00000, 1'b1, 1, PIX_FULL);
        for (int l = 0; l < 5; l++) drive_norm(l);
        h_sync = 1'b1; v_sync = 1'b1; rgb = 6'd0; clear_err = 1'b0;
        repeat (2100) @(negedge pixel_clk);
        chk("saturated_quiet", 64'({err, locked}), 64'b000001);
        drive_norm(5);
        chk("saturated_hper", 64'({err, locked}), 64'b000010);

        repeat (5) @(negedge pixel_clk);
        chk("pending_pulses", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
